// File: rtl/register_file_dump_if.sv
// Dump stream between the register file and the debug/UART consumer.
// master: register file side (sources beats); slave: consumer side.
interface register_file_dump_if #(
  parameter int REGS  = 5,
  parameter int NBITS = 32
) ();
  logic             dump_start;
  logic             dump_ready;
  logic             dump_valid;
  logic [REGS-1:0]  dump_addr;
  logic [NBITS-1:0] dump_data;
  logic             dump_busy;
  logic             dump_done;

  modport master (
    input  dump_start, dump_ready,
    output dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );

  modport slave (
    output dump_start, dump_ready,
    input  dump_valid, dump_addr, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/register_file_dump.sv
// MIPS general-purpose register file for the ID stage: two async read
// ports, one step-gated write port, a never-bypassed debug read port and
// a handshaked engine that streams every register (index, value) out.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to
// the rs/rt read ports; left undefined, reads see stored contents only.
//
// Dump FSM
//   state | meaning
//   IDLE  | waiting for dump_start
//   SEND  | beat at dump_addr presented, advances on dump_ready
//   DONE  | last beat accepted, one-cycle done pulse
module register_file_dump #(
  parameter int NREGS   = 32,
  parameter int REGS    = 5,
  parameter int NBITS   = 32,
  parameter int R0_ZERO = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_RegWrite,
  input  logic              i_step,
  input  logic [REGS-1:0]   i_RD,
  input  logic [NBITS-1:0]  i_DatoEscritura,
  input  logic [REGS-1:0]   i_dir_rs,
  input  logic [REGS-1:0]   i_dir_rt,
  output logic [NBITS-1:0]  o_data_rs,
  output logic [NBITS-1:0]  o_data_rt,
  input  logic [REGS-1:0]   i_RegDebug,
  output logic [NBITS-1:0]  o_RegDebug,
  register_file_dump_if.master dump
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [REGS:0]   NREGS_W = (REGS+1)'(NREGS);
  localparam logic [REGS-1:0] LAST    = REGS'(NREGS - 1);

  logic [NBITS-1:0] mem [NREGS];

  state_t           state_q, state_d;
  logic [REGS-1:0]  addr_q, addr_d;
  logic [NBITS-1:0] data_q;
  logic             load;
  logic             wr_en;

  logic [NBITS-1:0] rs_stored, rt_stored, dbg_stored, ld_stored, ld_val;

  function automatic logic addr_ok(input logic [REGS-1:0] a);
    return ({1'b0, a} < NREGS_W);
  endfunction

  function automatic logic is_zero_reg(input logic [REGS-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  assign wr_en = i_RegWrite && i_step && addr_ok(i_RD) && !is_zero_reg(i_RD);

  // Register array: reset loads each register with its own index.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= NBITS'(i);
      end
    end else if (wr_en) begin
      mem[i_RD] <= i_DatoEscritura;
    end
  end

  // Stored-value reads; out-of-range and the hard-wired zero register read 0.
  always_comb begin
    rs_stored  = '0;
    rt_stored  = '0;
    dbg_stored = '0;
    ld_stored  = '0;
    if (addr_ok(i_dir_rs)   && !is_zero_reg(i_dir_rs))   rs_stored  = mem[i_dir_rs];
    if (addr_ok(i_dir_rt)   && !is_zero_reg(i_dir_rt))   rt_stored  = mem[i_dir_rt];
    if (addr_ok(i_RegDebug) && !is_zero_reg(i_RegDebug)) dbg_stored = mem[i_RegDebug];
    if (addr_ok(addr_d)     && !is_zero_reg(addr_d))     ld_stored  = mem[addr_d];
  end

`ifdef REGFILE_BYPASS_EN
  assign o_data_rs = (wr_en && (i_dir_rs == i_RD)) ? i_DatoEscritura : rs_stored;
  assign o_data_rt = (wr_en && (i_dir_rt == i_RD)) ? i_DatoEscritura : rt_stored;
`else
  assign o_data_rs = rs_stored;
  assign o_data_rt = rt_stored;
`endif

  assign o_RegDebug = dbg_stored;

  // A beat snapshot includes a write landing on the same edge, so the
  // value streamed matches what the register holds after that edge.
  assign ld_val = (wr_en && (i_RD == addr_d)) ? i_DatoEscritura : ld_stored;

  // Dump FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Dump FSM next state, next beat index and load strobe.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dump.dump_start) begin
          state_d = ST_SEND;
          addr_d  = '0;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (dump.dump_ready) begin
          if (addr_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + 1'b1;
            load   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Beat registers: held stable until the consumer accepts the beat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      if (load) data_q <= ld_val;
    end
  end

  assign dump.dump_valid = (state_q == ST_SEND);
  assign dump.dump_busy  = (state_q != ST_IDLE);
  assign dump.dump_done  = (state_q == ST_DONE);
  assign dump.dump_addr  = addr_q;
  assign dump.dump_data  = data_q;

endmodule

// File: tb/tb_register_file_dump.sv
// Bench for register_file_dump: directed vector table, dump sequences
// (stall, chained start, mid-dump reset) and randomized reads/writes
// against an array model, on an R0_ZERO=1 and an R0_ZERO=0 instance.
module tb_register_file_dump;
  localparam int NREGS = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] BYP9 = BYP ? 32'hA5A5A5A5 : 32'd9;

  logic clk = 1'b0;
  logic rst_n;
  logic we, step;
  logic [4:0] rd, rs, rt, dbg;
  logic [31:0] wdata;
  logic [31:0] rs0, rt0, dbg0, rs1, rt1, dbg1;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m0 [NREGS];
  logic [31:0] m1 [NREGS];
  logic [31:0] snap [NREGS];

  always #5 clk = ~clk;

  register_file_dump_if #(.REGS(5), .NBITS(32)) if0 ();
  register_file_dump_if #(.REGS(5), .NBITS(32)) if1 ();

  register_file_dump #(.NREGS(NREGS), .REGS(5), .NBITS(32), .R0_ZERO(1)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_RegWrite(we), .i_step(step),
    .i_RD(rd), .i_DatoEscritura(wdata), .i_dir_rs(rs), .i_dir_rt(rt),
    .o_data_rs(rs0), .o_data_rt(rt0), .i_RegDebug(dbg), .o_RegDebug(dbg0),
    .dump(if0.master)
  );

  register_file_dump #(.NREGS(NREGS), .REGS(5), .NBITS(32), .R0_ZERO(0)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_RegWrite(we), .i_step(step),
    .i_RD(rd), .i_DatoEscritura(wdata), .i_dir_rs(rs), .i_dir_rt(rt),
    .o_data_rs(rs1), .o_data_rt(rt1), .i_RegDebug(dbg), .o_RegDebug(dbg1),
    .dump(if1.master)
  );

  typedef struct {
    logic        we;
    logic        step;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_rs1;
    logic [31:0] e_dbg;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m0[i] = i;
      m1[i] = i;
    end
  endtask

  // Register value seen by a read port; r0 selects the zero-register flavour.
  function automatic logic [31:0] mread(input bit r0, input int a, input bit byp);
    if (a >= NREGS || (r0 && a == 0)) return 32'd0;
    if (byp && BYP && we && step && a == int'(rd)) return wdata;
    return r0 ? m0[a] : m1[a];
  endfunction

  // Advance one clock; the model takes the write the DUT samples at this edge.
  task automatic tick();
    @(posedge clk);
    if (we && step) begin
      if (rd != 5'd0) m0[rd] = wdata;
      m1[rd] = wdata;
    end
    #1;
  endtask

  // Full dump starting in the current (IDLE) cycle. Optional stall at one
  // beat with a write to that register, optional write of the next beat's
  // register on each accepting edge, optional start held high throughout.
  task automatic dump_run(input int stall_idx, input int stall_n, input bit hold_start,
                          input bit wr_ahead);
    int idx;
    int stalled;
    bit stall;
    if0.dump_start = 1'b1;
    if0.dump_ready = 1'b1;
    we = 1'b0;
    @(negedge clk);
    chk("idle_busy", if0.dump_busy, 0);
    chk("idle_valid", if0.dump_valid, 0);
    chk("idle_done", if0.dump_done, 0);
    tick();
    snap[0] = mread(1, 0, 0);
    if (!hold_start) if0.dump_start = 1'b0;
    idx = 0;
    stalled = 0;
    for (int c = 0; c < NREGS + stall_n && idx < NREGS; c++) begin
      stall = (idx == stall_idx) && (stalled < stall_n);
      if0.dump_ready = !stall;
      step = 1'b1;
      if (stall) begin
        we = 1'b1; rd = 5'(idx); wdata = 32'h000000FF;
      end else if (wr_ahead && idx + 1 < NREGS && idx + 1 != stall_idx) begin
        we = 1'b1; rd = 5'(idx + 1); wdata = $urandom;
      end else begin
        we = 1'b0;
      end
      @(negedge clk);
      chk("beat_valid", if0.dump_valid, 1);
      chk("beat_addr", if0.dump_addr, idx);
      chk("beat_data", if0.dump_data, snap[idx]);
      chk("beat_done", if0.dump_done, 0);
      tick();
      if (stall) begin
        stalled++;
      end else begin
        idx++;
        if (idx < NREGS) snap[idx] = mread(1, idx, 0);
      end
    end
    chk("dump_beats", idx, NREGS);
    if0.dump_start = 1'b0;
    if0.dump_ready = 1'b1;
    we = 1'b0;
    @(negedge clk);
    chk("done_valid", if0.dump_valid, 0);
    chk("done_pulse", if0.dump_done, 1);
    chk("done_busy", if0.dump_busy, 1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; step = 1'b0; rd = '0; wdata = '0;
    rs = 5'd7; rt = 5'd31; dbg = 5'd5;
    if0.dump_start = 1'b0; if0.dump_ready = 1'b0;
    if1.dump_start = 1'b0; if1.dump_ready = 1'b0;
    model_reset();

    tv[0] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd31, 5'd5, 32'd7,        32'd31,       32'd7,        32'd5};
    tv[1] = '{1'b1, 1'b0, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0,  5'd3, 32'd3,        32'd0,        32'd3,        32'd3};
    tv[2] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3,  5'd5, 32'd3,        32'd3,        32'd3,        32'd5};
    tv[3] = '{1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 5'd4, 5'd5,  5'd3, 32'd4,        32'd5,        32'd4,        32'd3};
    tv[4] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd2,  5'd3, 32'hDEADBEEF, 32'd2,        32'hDEADBEEF, 32'hDEADBEEF};
    tv[5] = '{1'b1, 1'b1, 5'd0, 32'h1234,     5'd1, 5'd1,  5'd0, 32'd1,        32'd1,        32'd1,        32'd0};
    tv[6] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  5'd5, 32'd0,        32'd0,        32'h1234,     32'd5};
    tv[7] = '{1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd8,  5'd9, BYP9,         32'd8,        BYP9,         32'd9};
    tv[8] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd9,  5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};

    // Reset state
    @(negedge clk);
    chk("rst_valid", if0.dump_valid, 0);
    chk("rst_busy", if0.dump_busy, 0);
    chk("rst_done", if0.dump_done, 0);
    chk("rst_addr", if0.dump_addr, 0);
    chk("rst_data", if0.dump_data, 0);
    chk("rst_rs7", rs0, 7);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      we = tv[i].we; step = tv[i].step; rd = tv[i].rd; wdata = tv[i].wd;
      rs = tv[i].rs; rt = tv[i].rt; dbg = tv[i].dbg;
      @(negedge clk);
      chk($sformatf("vec%0d_rs", i), rs0, tv[i].e_rs);
      chk($sformatf("vec%0d_rt", i), rt0, tv[i].e_rt);
      chk($sformatf("vec%0d_rs_r0ord", i), rs1, tv[i].e_rs1);
      chk($sformatf("vec%0d_dbg", i), dbg0, tv[i].e_dbg);
      tick();
    end
    we = 1'b0;

    // Fresh contents, then two back-to-back dumps: first with start held
    // high (ignored while busy), second started in the IDLE cycle right
    // after DONE, stalled at beat 4 while reg 4 is rewritten.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    dump_run(-1, 0, 1'b1, 1'b0);
    dump_run(4, 3, 1'b0, 1'b1);
    we = 1'b0; rs = 5'd4; rt = 5'd0;
    @(negedge clk);
    chk("post_done", if0.dump_done, 0);
    chk("post_busy", if0.dump_busy, 0);
    chk("reg4_written", rs0, 32'h000000FF);
    tick();

    // Reset in the middle of a dump
    if0.dump_start = 1'b1;
    if0.dump_ready = 1'b1;
    tick();
    if0.dump_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    chk("abort_valid", if0.dump_valid, 0);
    chk("abort_busy", if0.dump_busy, 0);
    chk("abort_addr", if0.dump_addr, 0);
    chk("abort_data", if0.dump_data, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs = 5'd4; rt = 5'd3;
      @(negedge clk);
      chk("abort_no_done", if0.dump_done, 0);
      chk("abort_idle", if0.dump_busy, 0);
      chk("abort_rs", rs0, 4);
      tick();
    end

    // Randomized reads/writes against the array model
    for (int c = 0; c < 300; c++) begin
      we    = ($urandom_range(0, 3) != 0);
      step  = ($urandom_range(0, 3) != 0);
      rd    = 5'($urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 7) == 0) rd = 5'd0;
      wdata = $urandom;
      rs    = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      rt    = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      dbg   = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      @(negedge clk);
      chk("rnd_rs", rs0, mread(1, rs, 1));
      chk("rnd_rt", rt0, mread(1, rt, 1));
      chk("rnd_dbg", dbg0, mread(1, dbg, 0));
      chk("rnd_rs_r0ord", rs1, mread(0, rs, 1));
      chk("rnd_rt_r0ord", rt1, mread(0, rt, 1));
      chk("rnd_dbg_r0ord", dbg1, mread(0, dbg, 0));
      tick();
    end
    we = 1'b0;
    @(negedge clk);
    chk("idle_inst1_busy", if1.dump_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
